// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: default queue geometry and the bit layout
// of one decoded instruction bundle as it travels from decode to rename.
package decode_pkg;

    localparam int DEFAULT_LANES = 2;
    localparam int DEFAULT_DEPTH = 8;

    // Bundle fields, packed upward from bit 0.
    localparam int PC_W                  = 32;
    localparam int PC_LSB                = 0;
    localparam int PRE_DIRECTION_W       = 1;
    localparam int PRE_DIRECTION_LSB     = PC_LSB + PC_W;
    localparam int RS_WRITE_W            = 1;
    localparam int RS_WRITE_LSB          = PRE_DIRECTION_LSB + PRE_DIRECTION_W;
    localparam int RS1_READ_W            = 1;
    localparam int RS1_READ_LSB          = RS_WRITE_LSB + RS_WRITE_W;
    localparam int RI2_W                 = 1;
    localparam int RI2_LSB               = RS1_READ_LSB + RS1_READ_W;
    localparam int RD_WRITE_W            = 1;
    localparam int RD_WRITE_LSB          = RI2_LSB + RI2_W;
    localparam int ST_W                  = 1;
    localparam int ST_LSB                = RD_WRITE_LSB + RD_WRITE_W;
    localparam int DETECT_FIRST_RESULT_W = 1;
    localparam int DETECT_FIRST_RESULT_LSB = ST_LSB + ST_W;
    localparam int RS_NUM_W              = 2;
    localparam int RS_NUM_LSB            = DETECT_FIRST_RESULT_LSB + DETECT_FIRST_RESULT_W;
    localparam int BR_TYPE_W             = 3;
    localparam int BR_TYPE_LSB           = RS_NUM_LSB + RS_NUM_W;
    localparam int RS_CTRL_W             = 6;
    localparam int RS_CTRL_LSB           = BR_TYPE_LSB + BR_TYPE_W;
    localparam int RS1_W                 = 5;
    localparam int RS1_LSB               = RS_CTRL_LSB + RS_CTRL_W;
    localparam int RS2_W                 = 5;
    localparam int RS2_LSB               = RS1_LSB + RS1_W;
    localparam int RD_W                  = 5;
    localparam int RD_LSB                = RS2_LSB + RS2_W;
    localparam int LD_ST_NUM_W           = 2;
    localparam int LD_ST_NUM_LSB         = RD_LSB + RD_W;
    localparam int IMM_W                 = 32;
    localparam int IMM_LSB               = LD_ST_NUM_LSB + LD_ST_NUM_W;
    localparam int NEXT_PC_W             = 32;
    localparam int NEXT_PC_LSB           = IMM_LSB + IMM_W;
    localparam int RS_BRU_PC_W           = 32;
    localparam int RS_BRU_PC_LSB         = NEXT_PC_LSB + NEXT_PC_W;
    localparam int IS_SPLIT_W            = 1;
    localparam int IS_SPLIT_LSB          = RS_BRU_PC_LSB + RS_BRU_PC_W;
    localparam int INSTR_VALID_W         = 1;
    localparam int INSTR_VALID_LSB       = IS_SPLIT_LSB + IS_SPLIT_W;

    // Total bundle width (165 bits).
    localparam int PAYLOAD_W = INSTR_VALID_LSB + INSTR_VALID_W;

endpackage

// File: rtl/lane_compact.sv
// Lane compaction helper: counts the set lanes of a sparse valid vector and
// gives each lane its dense write slot (number of valid lanes below it).
module lane_compact #(
    parameter int LANES = 2
) (
    input  logic [LANES-1:0]                  valid,
    output logic [$clog2(LANES+1)-1:0]        total,
    output logic [LANES*$clog2(LANES+1)-1:0]  slot
);

    localparam int LW = $clog2(LANES + 1);

    logic [LW-1:0] acc;

    // Running prefix sum over lanes in ascending order.
    always_comb begin
        acc  = '0;
        slot = '0;
        // NOTE: blocking assignments here make acc a running value within one
        // evaluation; non-blocking would read the stale value every iteration.
        for (int i = 0; i < LANES; i++) begin
            slot[i*LW +: LW] = acc;
            acc              = acc + LW'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/decode_rename_queue.sv
// Circular multi-lane queue between decode and rename. Sparse decode lanes
// are compacted on write; rename sees the oldest LANES entries, lane 0 oldest.
module decode_rename_queue #(
    parameter int LANES     = decode_pkg::DEFAULT_LANES,
    parameter int PAYLOAD_W = decode_pkg::PAYLOAD_W,
    parameter int DEPTH     = decode_pkg::DEFAULT_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [LANES-1:0]                enq_valid,
    input  logic [LANES*PAYLOAD_W-1:0]      enq_data,
    output logic                            enq_ready,
    output logic [LANES-1:0]                deq_valid,
    output logic [LANES*PAYLOAD_W-1:0]      deq_data,
    input  logic [$clog2(LANES+1)-1:0]      deq_count,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            err_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LW    = $clog2(LANES + 1);

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;

    logic [LW-1:0]        n_enq;
    logic [LANES*LW-1:0]  enq_slot;
    logic                 enq_fire;
    logic [CNT_W-1:0]     n_enq_eff;
    logic [CNT_W-1:0]     avail;
    logic [CNT_W-1:0]     deq_req;
    logic                 underflow;
    logic [CNT_W-1:0]     n_deq;
    logic [CNT_W-1:0]     count_next;

    lane_compact #(.LANES(LANES)) u_lane_compact (
        .valid (enq_valid),
        .total (n_enq),
        .slot  (enq_slot)
    );

    // Room for a whole LANES-wide group, judged on registered occupancy only.
    assign enq_ready = (count <= CNT_W'(DEPTH - LANES));
    assign enq_fire  = enq_ready && (|enq_valid) && !flush;
    assign n_enq_eff = enq_fire ? CNT_W'(n_enq) : '0;

    // Dequeue is clipped to what rename can actually see this cycle.
    assign avail      = (count > CNT_W'(LANES)) ? CNT_W'(LANES) : count;
    assign deq_req    = CNT_W'(deq_count);
    assign underflow  = (deq_req > avail);
    assign n_deq      = underflow ? avail : deq_req;
    assign count_next = count + n_enq_eff - n_deq;

    // Payload storage: compacted valid lanes land at tail, tail+1, ...
    // NOTE: the array has no reset; head/tail/count alone decide which
    // entries are live, so clearing the payload would only cost flops.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (enq_fire && enq_valid[i]) begin
                mem[tail + PTR_W'(enq_slot[i*LW +: LW])] <= enq_data[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // Pointer, occupancy and sticky-error state; flush outranks traffic.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            err_underflow <= 1'b0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_enq_eff);
            count <= count_next;
            if (underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // Read side: thermometer valids and zeroed data on empty lanes.
    for (genvar i = 0; i < LANES; i++) begin : g_deq
        assign deq_valid[i] = (count > CNT_W'(i));
        assign deq_data[i*PAYLOAD_W +: PAYLOAD_W] =
            deq_valid[i] ? mem[head + PTR_W'(i)] : '0;
    end

endmodule

// File: tb/tb_decode_rename_queue.sv
// Directed bench for decode_rename_queue at LANES=2, DEPTH=8; each payload
// carries a tag in its low and high bits so lane order is visible.
module tb_decode_rename_queue;

    localparam int LANES = 2;
    localparam int PW    = 165;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [1:0]      enq_valid;
    logic [2*PW-1:0] enq_data;
    logic            enq_ready;
    logic [1:0]      deq_valid;
    logic [2*PW-1:0] deq_data;
    logic [1:0]      deq_count;
    logic [3:0]      count;
    logic            err_underflow;

    int checks = 0;
    int errors = 0;
    int q[$];

    decode_rename_queue #(.LANES(LANES), .PAYLOAD_W(PW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .enq_valid     (enq_valid),
        .enq_data      (enq_data),
        .enq_ready     (enq_ready),
        .deq_valid     (deq_valid),
        .deq_data      (deq_data),
        .deq_count     (deq_count),
        .count         (count),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk(input int t);
        return {8'(t), 141'd0, 16'(t)};
    endfunction

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input int t0, input int t1, input logic [1:0] dc);
        enq_valid = v;
        enq_data  = {mk(t1), mk(t0)};
        deq_count = dc;
    endtask

    task automatic idle();
        drive(2'b00, 0, 0, 2'd0);
        flush = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input int t0, input int t1);
        check({tag, "_l0"}, 192'(deq_data[0 +: PW]), 192'(mk(t0)));
        check({tag, "_l1"}, 192'(deq_data[PW +: PW]), 192'(mk(t1)));
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #12;
        check("rst_count", 192'(count), 192'd0);
        check("rst_ready", 192'(enq_ready), 192'd1);
        check("rst_valid", 192'(deq_valid), 192'd0);
        check("rst_data", 192'(deq_data[191:0]), 192'd0);
        check("rst_err", 192'(err_underflow), 192'd0);
        reset = 1'b1;
        tick();
        check("idle_count", 192'(count), 192'd0);
        check("idle_data", 192'(deq_data[2*PW-1 -: 192]), 192'd0);

        // A,B in both lanes
        drive(2'b11, 1, 2, 2'd0);
        tick();
        idle();
        check("ab_count", 192'(count), 192'd2);
        check("ab_valid", 192'(deq_valid), 192'd3);
        check_lanes("ab", 1, 2);

        // C in lane 1 only; lane 0 carries junk that must not be stored
        drive(2'b10, 8'h99, 3, 2'd0);
        tick();
        idle();
        check("c_count", 192'(count), 192'd3);
        check_lanes("c_head", 1, 2);

        // Fill to 7: D,E then F,G
        drive(2'b11, 4, 5, 2'd0);
        tick();
        drive(2'b11, 6, 7, 2'd0);
        tick();
        idle();
        check("fill_count", 192'(count), 192'd7);
        check("fill_ready", 192'(enq_ready), 192'd0);
        drive(2'b11, 8'hE1, 8'hE2, 2'd0);
        tick();
        idle();
        check("blocked_count", 192'(count), 192'd7);

        // Pop A,B -> C,D at the head, room again
        drive(2'b00, 0, 0, 2'd2);
        tick();
        idle();
        check("pop_count", 192'(count), 192'd5);
        check("pop_ready", 192'(enq_ready), 192'd1);
        check_lanes("pop", 3, 4);

        drive(2'b00, 0, 0, 2'd2);
        tick();
        check_lanes("pop2", 5, 6);
        drive(2'b00, 0, 0, 2'd1);
        tick();
        idle();
        check("pop3_count", 192'(count), 192'd2);
        check_lanes("pop3", 6, 7);

        // Steady stream across pointer wrap: two in, two out each cycle
        q = '{6, 7};
        for (int k = 0; k < 20; k++) begin
            drive(2'b11, 100 + 2*k, 101 + 2*k, 2'd2);
            void'(q.pop_front());
            void'(q.pop_front());
            q.push_back(100 + 2*k);
            q.push_back(101 + 2*k);
            tick();
            check($sformatf("wrap%0d_count", k), 192'(count), 192'd2);
            check_lanes($sformatf("wrap%0d", k), q[0], q[1]);
        end
        idle();
        check("wrap_err", 192'(err_underflow), 192'd0);

        // Flush beats simultaneous enqueue and dequeue
        drive(2'b11, 8'hF1, 8'hF2, 2'd1);
        flush = 1'b1;
        tick();
        idle();
        check("flush_count", 192'(count), 192'd0);
        check("flush_valid", 192'(deq_valid), 192'd0);
        check("flush_data", 192'(deq_data[191:0]), 192'd0);
        tick();
        check("flush_idle_count", 192'(count), 192'd0);

        // Single entry: lane 1 empty and zeroed
        drive(2'b01, 8'h55, 8'h66, 2'd0);
        tick();
        idle();
        check("one_count", 192'(count), 192'd1);
        check("one_valid", 192'(deq_valid), 192'd1);
        check_lanes("one", 8'h55, 0);

        // Over-ask: only one entry leaves, error latches
        drive(2'b00, 0, 0, 2'd2);
        tick();
        idle();
        check("uf_count", 192'(count), 192'd0);
        check("uf_err", 192'(err_underflow), 192'd1);
        drive(2'b01, 8'h77, 0, 2'd0);
        tick();
        idle();
        check("uf_head_moved", 192'(deq_data[0 +: PW]), 192'(mk(8'h77)));
        flush = 1'b1;
        tick();
        idle();
        check("uf_sticky", 192'(err_underflow), 192'd1);

        // Asynchronous reset mid-traffic
        drive(2'b11, 1, 2, 2'd0);
        tick();
        drive(2'b11, 3, 4, 2'd1);
        #3;
        reset = 1'b0;
        #1;
        check("async_count", 192'(count), 192'd0);
        check("async_err", 192'(err_underflow), 192'd0);
        check("async_valid", 192'(deq_valid), 192'd0);
        idle();
        #10;
        reset = 1'b1;
        tick();
        check("after_rst_count", 192'(count), 192'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_rename_queue.md
Name: decode_rename_queue

Overview:
- Parametrised successor to the fixed 2-wide decode→rename pipeline register.
- Circular multi-lane queue that accepts up to LANES decoded instruction bundles per cycle from decode_stage and presents up to LANES bundles in order to rename.
- Decouples decode from rename stalls, compacts sparse decode lanes, and supports a single-cycle flush on recover.

Parameters:
- LANES, 2, instructions enqueued/dequeued per cycle (1..4)
- PAYLOAD_W, 165, bits per decoded instruction bundle
- DEPTH, 8, queue entries (one instruction each); power of 2, DEPTH >= 2*LANES
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)
- CNT_W, $clog2(DEPTH+1), occupancy width (derived)
- LW, $clog2(LANES+1), lane-count width (derived)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  recover/mispredict flush, synchronous
- enq_valid  in  LANES  per-lane valid from decode; holes allowed
- enq_data  in  LANES*PAYLOAD_W  lane i at bits [i*PAYLOAD_W +: PAYLOAD_W]
- enq_ready  out  1  queue can take a full LANES-wide group this cycle
- deq_valid  out  LANES  lane i holds the (i+1)-th oldest entry; thermometer-coded
- deq_data  out  LANES*PAYLOAD_W  oldest entries, lane 0 = oldest
- deq_count  in  LW  entries rename consumes this cycle
- count  out  CNT_W  current occupancy
- err_underflow  out  1  sticky: deq_count exceeded valid lanes

Behaviour:
- Storage: DEPTH x PAYLOAD_W array; head, tail PTR_W pointers; count register. Pointers wrap modulo DEPTH via natural PTR_W overflow.
- Reset (reset=0, asynchronous): head=tail=0, count=0, err_underflow=0, deq_valid=0, deq_data=0, enq_ready=1. Array contents are not reset.
- enq_ready = (DEPTH - count) >= LANES, computed from registered count only. A same-cycle dequeue never raises enq_ready; there is no combinational ready→valid path.
- Enqueue fires when enq_ready=1 and |enq_valid. n_enq = popcount(enq_valid).
  - Valid lanes are compacted in ascending lane order into mem[tail], mem[tail+1], … mod DEPTH.
  - tail advances by n_enq.
  - When enq_ready=0, enq inputs are ignored and decode must hold.
- Dequeue:
  - n_deq = min(deq_count, number of set deq_valid bits); head advances by n_deq.
  - If deq_count > valid lanes, err_underflow sets and stays set until reset.
- deq_valid[i] = (count > i). deq_data lane i = mem[head+i mod DEPTH] when valid, otherwise 0.
  - Outputs derive from registered state only.
- Latency: a bundle enqueued in cycle t appears on deq lanes at cycle t+1 at the earliest.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Entries dequeued this cycle are reusable from the next cycle.
- Full (count=DEPTH): enq_ready=0 and all deq lanes valid.
- Empty: deq_valid=0 and deq_data=0.
- flush=1 has priority over everything: head=tail=0, count=0 next cycle. Same-cycle enqueue and dequeue are discarded. err_underflow is unaffected.
- Reset asserted mid-operation clears state immediately, regardless of flush or traffic.
- Ordering: program order is preserved across lanes and across wrap-around.

Decomposition:
- Shared package decode_pkg holds:
  - PAYLOAD_W
  - field offsets/widths of the bundle: pc, pre_direction, rs_write, rs1_read, ri2, rd_write, st, detect_first_result, rs_num, br_type, rs_ctrl, rs1, rs2, rd, ld_st_num, imm, next_pc, rs_bru_pc, is_split, instr_valid
  - the default LANES/DEPTH constants
- One sub-module, lane_compact: combinational popcount plus prefix-sum write-slot computation for enq_valid, reused by the later rename-stage free-list allocator.

Test Plan (LANES=2, DEPTH=8, payload = lane tag):
- Reset then idle → count=0, deq_valid=2'b00, enq_ready=1, deq_data=0.
- Enqueue enq_valid=2'b11 (A,B), deq_count=0 → next cycle count=2, deq_valid=2'b11, lane0=A, lane1=B.
- Enqueue enq_valid=2'b10 (hole in lane 0, data C) → C written to a single entry; count increases by 1; C appears after B.
- Fill to 7 entries → enq_ready=0. Enqueue attempt is ignored; count stays 7.
- Then deq_count=2 in one cycle → count=5 and enq_ready=1 the following cycle.
- Wrap: 20 cycles with continuous enq 2'b11 and deq_count=2 → outputs arrive in exact order with pointers wrapping and count constant at 2.
- flush with enq_valid=2'b11 and deq_count=1 in the same cycle → next cycle count=0, deq_valid=0.
- deq_count=2 with count=1 → head advances by 1 and err_underflow=1, remaining set until reset.
